ascon_aead_stream: RTL

- Parametrised successor of the fixed 2+2-block decrypt datapath.
- Takes the post-initialization Ascon state and absorbs a runtime-selected number of associated-data blocks.
- Then encrypts or decrypts a runtime-selected number of message blocks over valid/ready streams.
- Returns the pre-finalization state for the tag stage; sits between the initialization and finalization blocks.

---
 rtl/ascon_pkg.sv | 48 ++++
 rtl/ascon_permutation.sv | 43 ++++
 rtl/ascon_aead_stream.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types, constants and the Ascon round function used by the
// AEAD stream datapath and its permutation core.
package ascon_pkg;

  // x0 is element 0, the most-significant 64 bits of the packed 320-bit state.
  typedef logic [0:4][63:0] ascon_state_t;

  typedef enum logic {
    ENCRYPT = 1'b0,
    DECRYPT = 1'b1
  } ascon_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AD_WAIT,
    S_AD_PERM,
    S_DOMSEP,
    S_MSG_WAIT,
    S_MSG_OUT,
    S_MSG_PERM,
    S_DONE
  } aead_state_e;

  localparam logic [63:0] DSEP_CONST = 64'h1;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;

  function automatic logic [63:0] ror64(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round with round index r (0..11): constant, bitsliced S-box, linear layer.
  function automatic ascon_state_t ascon_round(ascon_state_t s, logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ {56'h0, ~r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

endpackage

// File: rtl/ascon_permutation.sv
// ascon_permutation: iterative p^ROUNDS, one round per cycle. A single-cycle
// start_i captures state_i; done_o is high for one cycle when state_o is final.
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int ROUNDS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         done_o
);

  ascon_state_t s_q;
  logic [3:0]   rnd_q;
  logic         run_q;

  // Capture on start, then apply the last ROUNDS rounds of the 12-round schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      rnd_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      s_q   <= state_i;
      rnd_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (rnd_q == 4'(ROUNDS)) begin
        run_q <= 1'b0;
      end else begin
        s_q   <= ascon_round(s_q, 4'(12 - ROUNDS) + rnd_q);
        rnd_q <= rnd_q + 4'd1;
      end
    end
  end

  assign state_o = s_q;
  assign done_o  = run_q && (rnd_q == 4'(ROUNDS));

endmodule

// File: rtl/ascon_aead_stream.sv
// ascon_aead_stream: absorbs ad_len AD blocks into the initialized Ascon state,
// applies domain separation, then encrypts/decrypts msg_len message blocks over
// valid/ready streams and returns the pre-finalization state.
// Optional macro ASCON_PARTIAL_LAST_EN adds in_last_bytes for a padded,
// partial last message block (0 means a full 8-byte block).
module ascon_aead_stream
  import ascon_pkg::*;
#(
  parameter int MAX_AD_BLOCKS  = 8,
  parameter int MAX_MSG_BLOCKS = 8,
  parameter int PB_ROUNDS      = 6,
  localparam int AD_W  = $clog2(MAX_AD_BLOCKS + 1),
  localparam int MSG_W = $clog2(MAX_MSG_BLOCKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [AD_W-1:0]  ad_len,
  input  logic [MSG_W-1:0] msg_len,
  input  logic [319:0]     state_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
`ifdef ASCON_PARTIAL_LAST_EN
  input  logic [2:0]       in_last_bytes,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [319:0]     state_out,
  output logic             busy,
  output logic             done
);

  aead_state_e      fsm_q, fsm_d;
  ascon_mode_e      mode_q, mode_d;
  logic [AD_W-1:0]  ad_len_q, ad_len_d, ad_cnt_q, ad_cnt_d;
  logic [MSG_W-1:0] msg_len_q, msg_len_d, msg_cnt_q, msg_cnt_d;
  ascon_state_t     st_q, st_d, state_out_q, state_out_d;
  logic [63:0]      out_q, out_d;
  logic             perm_start, perm_done;
  logic [319:0]     perm_state;
  logic [63:0]      blk_mask, blk_pad;

`ifdef ASCON_PARTIAL_LAST_EN
  logic       last_blk;
  logic [3:0] nbytes;
  assign last_blk = (msg_cnt_q + MSG_W'(1)) == msg_len_q;
  assign nbytes   = (last_blk && in_last_bytes != 3'd0) ? {1'b0, in_last_bytes} : 4'd8;
  assign blk_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {nbytes, 3'b000});
  assign blk_pad  = (nbytes == 4'd8) ? 64'h0
                  : ({56'h0, PAD_BYTE} << (7'd56 - {nbytes, 3'b000}));
`else
  assign blk_mask = '1;
  assign blk_pad  = '0;
`endif

  ascon_permutation #(.ROUNDS(PB_ROUNDS)) u_perm (
    .clk    (clk),
    .rst    (rst),
    .start_i(perm_start),
    .state_i(st_d),
    .state_o(perm_state),
    .done_o (perm_done)
  );

  // Next-state, datapath update and handshake outputs of the block FSM.
  always_comb begin
    fsm_d       = fsm_q;
    mode_d      = mode_q;
    ad_len_d    = ad_len_q;
    msg_len_d   = msg_len_q;
    ad_cnt_d    = ad_cnt_q;
    msg_cnt_d   = msg_cnt_q;
    st_d        = st_q;
    out_d       = out_q;
    state_out_d = state_out_q;
    perm_start  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (fsm_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mode_d    = ascon_mode_e'(mode);
          ad_len_d  = ad_len;
          msg_len_d = msg_len;
          st_d      = state_in;
          ad_cnt_d  = '0;
          msg_cnt_d = '0;
          fsm_d     = (ad_len != '0) ? S_AD_WAIT : S_DOMSEP;
        end
      end
      S_AD_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d[0]    = st_q[0] ^ in_data;
          ad_cnt_d   = ad_cnt_q + AD_W'(1);
          perm_start = 1'b1;
          fsm_d      = S_AD_PERM;
        end
      end
      S_AD_PERM: begin
        if (perm_done) begin
          st_d  = perm_state;
          fsm_d = (ad_cnt_q == ad_len_q) ? S_DOMSEP : S_AD_WAIT;
        end
      end
      S_DOMSEP: begin
        st_d[4] = st_q[4] ^ DSEP_CONST;
        fsm_d   = (msg_len_q != '0) ? S_MSG_WAIT : S_DONE;
      end
      S_MSG_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          out_d     = (st_q[0] ^ in_data) & blk_mask;
          msg_cnt_d = msg_cnt_q + MSG_W'(1);
          if (mode_q == ENCRYPT) st_d[0] = st_q[0] ^ (in_data & blk_mask) ^ blk_pad;
          else st_d[0] = ((in_data & blk_mask) | (st_q[0] & ~blk_mask)) ^ blk_pad;
          fsm_d = S_MSG_OUT;
        end
      end
      S_MSG_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (msg_cnt_q == msg_len_q) begin
            fsm_d = S_DONE;
          end else begin
            perm_start = 1'b1;
            fsm_d      = S_MSG_PERM;
          end
        end
      end
      S_MSG_PERM: begin
        if (perm_done) begin
          st_d  = perm_state;
          fsm_d = S_MSG_WAIT;
        end
      end
      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        state_out_d = st_q;
        fsm_d       = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Register FSM, latched operation parameters, counters and the working state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      mode_q      <= ENCRYPT;
      ad_len_q    <= '0;
      msg_len_q   <= '0;
      ad_cnt_q    <= '0;
      msg_cnt_q   <= '0;
      st_q        <= '0;
      out_q       <= '0;
      state_out_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      ad_len_q    <= ad_len_d;
      msg_len_q   <= msg_len_d;
      ad_cnt_q    <= ad_cnt_d;
      msg_cnt_q   <= msg_cnt_d;
      st_q        <= st_d;
      out_q       <= out_d;
      state_out_q <= state_out_d;
    end
  end

  assign out_data  = out_q;
  assign state_out = state_out_q;

endmodule
